// File: rtl/tick_time_counter.sv
// tick_time_counter: packed-BCD hh:mm:ss clock advanced by edges of a pulse timebase, with a checked load port.
// Define TIME_12H_EN for 12-hour display (hours 12,01..11) with o_pm and i_set_pm.
module tick_time_counter #(
   parameter int TICKS_PER_SEC = 10
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic       i_pulse,
   input  logic       i_run,
   input  logic       i_set_valid,
   input  logic [7:0] i_set_hh,
   input  logic [7:0] i_set_mm,
   input  logic [7:0] i_set_ss,
`ifdef TIME_12H_EN
   input  logic       i_set_pm,
   output logic       o_pm,
`endif
   output logic [7:0] o_hh,
   output logic [7:0] o_mm,
   output logic [7:0] o_ss,
   output logic       o_sec_tick,
   output logic       o_set_ack,
   output logic       o_set_err
);

   typedef struct packed {
      logic [7:0] hh;
      logic [7:0] mm;
      logic [7:0] ss;
   } bcd_time_t;

   localparam logic [7:0] SUB_MAX = 8'(TICKS_PER_SEC - 1);
`ifdef TIME_12H_EN
   localparam logic [7:0] HH_RST = 8'h12;
`else
   localparam logic [7:0] HH_RST = 8'h00;
`endif

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic digits_ok(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   logic      r_pulse_d;
   logic [7:0] r_sub;
   logic      tick;
   logic      set_legal;
   bcd_time_t set_req;
   bcd_time_t nxt;
   logic      ss_wrap;
   logic      mm_wrap;
`ifdef TIME_12H_EN
   logic      pm_nxt;
`endif

   assign tick    = i_pulse & ~r_pulse_d;
   assign set_req = {i_set_hh, i_set_mm, i_set_ss};

   // Packed BCD compares numerically once every digit is known to be 0..9.
   always_comb begin
      set_legal = digits_ok(set_req.hh) && digits_ok(set_req.mm) && digits_ok(set_req.ss) &&
                  (set_req.mm <= 8'h59) && (set_req.ss <= 8'h59);
`ifdef TIME_12H_EN
      set_legal = set_legal && (set_req.hh >= 8'h01) && (set_req.hh <= 8'h12);
`else
      set_legal = set_legal && (set_req.hh <= 8'h23);
`endif
   end

   always_comb begin
      ss_wrap = (o_ss == 8'h59);
      mm_wrap = (o_mm == 8'h59);
      nxt.ss  = ss_wrap ? 8'h00 : bcd_inc(o_ss);
      nxt.mm  = o_mm;
      nxt.hh  = o_hh;
`ifdef TIME_12H_EN
      pm_nxt  = o_pm;
`endif
      if (ss_wrap) nxt.mm = mm_wrap ? 8'h00 : bcd_inc(o_mm);
      if (ss_wrap && mm_wrap) begin
`ifdef TIME_12H_EN
         // AM/PM flips entering 12 o'clock, not leaving it.
         nxt.hh = (o_hh == 8'h12) ? 8'h01 : bcd_inc(o_hh);
         if (o_hh == 8'h11) pm_nxt = ~o_pm;
`else
         nxt.hh = (o_hh == 8'h23) ? 8'h00 : bcd_inc(o_hh);
`endif
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_pulse_d  <= 1'b1;
         r_sub      <= 8'd0;
         o_hh       <= HH_RST;
         o_mm       <= 8'h00;
         o_ss       <= 8'h00;
         o_sec_tick <= 1'b0;
         o_set_ack  <= 1'b0;
         o_set_err  <= 1'b0;
`ifdef TIME_12H_EN
         o_pm       <= 1'b0;
`endif
      end else begin
         r_pulse_d  <= i_pulse;
         o_sec_tick <= 1'b0;
         o_set_ack  <= 1'b0;
         o_set_err  <= 1'b0;
         // A set request swallows any coincident tick.
         if (i_set_valid) begin
            if (set_legal) begin
               o_hh      <= set_req.hh;
               o_mm      <= set_req.mm;
               o_ss      <= set_req.ss;
               r_sub     <= 8'd0;
               o_set_ack <= 1'b1;
`ifdef TIME_12H_EN
               o_pm      <= i_set_pm;
`endif
            end else begin
               o_set_err <= 1'b1;
            end
         end else if (tick && i_run) begin
            if (r_sub == SUB_MAX) begin
               r_sub      <= 8'd0;
               o_hh       <= nxt.hh;
               o_mm       <= nxt.mm;
               o_ss       <= nxt.ss;
               o_sec_tick <= 1'b1;
`ifdef TIME_12H_EN
               o_pm       <= pm_nxt;
`endif
            end else begin
               r_sub <= r_sub + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tick_time_counter.sv
// Bench for tick_time_counter: directed corner cases plus random traffic against a seconds-of-day model.
// Also builds with TIME_12H_EN defined, matching the design's 12-hour variant.
module tb_tick_time_counter;
   localparam int TPS = 10;
   localparam int DAY = 86400;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       pulse = 1'b1;
   logic       run = 1'b0;
   logic       set_valid = 1'b0;
   logic [7:0] set_hh = 8'h00;
   logic [7:0] set_mm = 8'h00;
   logic [7:0] set_ss = 8'h00;
   logic [7:0] hh, mm, ss;
   logic       sec_tick, set_ack, set_err;
`ifdef TIME_12H_EN
   logic       set_pm = 1'b0;
   logic       pm;
`endif

   int n_vec = 0;
   int n_bad = 0;

   // Model state: time as seconds since midnight, sub-second tick count, last pulse level.
   int m_sod = 0;
   int m_sub = 0;
   bit m_prev = 1'b1;
   bit m_tick = 1'b0;
   bit m_ack = 1'b0;
   bit m_err = 1'b0;

   always #5 clk = ~clk;

   tick_time_counter #(.TICKS_PER_SEC(TPS)) dut (
      .i_clk       (clk),
      .i_rstn      (rstn),
      .i_pulse     (pulse),
      .i_run       (run),
      .i_set_valid (set_valid),
      .i_set_hh    (set_hh),
      .i_set_mm    (set_mm),
      .i_set_ss    (set_ss),
`ifdef TIME_12H_EN
      .i_set_pm    (set_pm),
      .o_pm        (pm),
`endif
      .o_hh        (hh),
      .o_mm        (mm),
      .o_ss        (ss),
      .o_sec_tick  (sec_tick),
      .o_set_ack   (set_ack),
      .o_set_err   (set_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return 8'((v / 10) * 16 + (v % 10));
   endfunction

   function automatic int from_bcd(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic bit nib_ok(input logic [7:0] b);
      return (b[7:4] < 4'd10) && (b[3:0] < 4'd10);
   endfunction

   function automatic logic [23:0] disp(input int sod);
      int h;
      h = sod / 3600;
`ifdef TIME_12H_EN
      h = (h % 12 == 0) ? 12 : h % 12;
`endif
      return {to_bcd(h), to_bcd((sod / 60) % 60), to_bcd(sod % 60)};
   endfunction

   function automatic bit legal(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      if (!(nib_ok(h) && nib_ok(m) && nib_ok(s))) return 1'b0;
      if (from_bcd(m) > 59 || from_bcd(s) > 59) return 1'b0;
`ifdef TIME_12H_EN
      return from_bcd(h) >= 1 && from_bcd(h) <= 12;
`else
      return from_bcd(h) <= 23;
`endif
   endfunction

   function automatic int set_sod();
      int h;
      h = from_bcd(set_hh);
`ifdef TIME_12H_EN
      h = (h % 12) + (set_pm ? 12 : 0);
`endif
      return h * 3600 + from_bcd(set_mm) * 60 + from_bcd(set_ss);
   endfunction

   task automatic model_reset();
      m_sod = 0; m_sub = 0; m_prev = 1'b1;
      m_tick = 1'b0; m_ack = 1'b0; m_err = 1'b0;
   endtask

   // One clock edge of the reference behaviour, using the inputs just sampled.
   task automatic model_step();
      bit tk;
      tk = pulse && !m_prev;
      m_prev = pulse;
      m_tick = 1'b0; m_ack = 1'b0; m_err = 1'b0;
      if (set_valid) begin
         if (legal(set_hh, set_mm, set_ss)) begin
            m_sod = set_sod(); m_sub = 0; m_ack = 1'b1;
         end else begin
            m_err = 1'b1;
         end
      end else if (tk && run) begin
         if (m_sub == TPS - 1) begin
            m_sub = 0; m_sod = (m_sod + 1) % DAY; m_tick = 1'b1;
         end else begin
            m_sub++;
         end
      end
   endtask

   task automatic check_all();
      chk("time", 32'({hh, mm, ss}), 32'(disp(m_sod)));
      chk("strobes", 32'({sec_tick, set_ack, set_err}), 32'({m_tick, m_ack, m_err}));
      chk("r_sub", 32'(dut.r_sub), 32'(m_sub));
`ifdef TIME_12H_EN
      chk("pm", 32'(pm), 32'(m_sod >= 43200));
`endif
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rstn) model_step();
      #1;
      check_all();
   endtask

   task automatic tick_n(input int n);
      repeat (n) begin
         pulse = 1'b1; cycle();
         pulse = 1'b0; cycle();
      end
   endtask

   task automatic drive_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input bit p);
      set_hh = h; set_mm = m; set_ss = s;
`ifdef TIME_12H_EN
      set_pm = p;
`else
      if (p) set_hh = h;
`endif
   endtask

   task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input bit p);
      drive_set(h, m, s, p);
      set_valid = 1'b1; cycle();
      set_valid = 1'b0;
   endtask

   // Asynchronous assert between edges; state must clear before any clock.
   task automatic do_reset();
      #2 rstn = 1'b0;
      #1 model_reset();
      check_all();
      repeat (2) @(posedge clk);
      #1 check_all();
      rstn = 1'b1;
   endtask

   initial begin
      #1 check_all();
      repeat (2) @(posedge clk);
      #1 check_all();
      rstn = 1'b1;
      run  = 1'b1;
      cycle();                      // pulse already high at release: no tick
      tick_n(10);                   // one second elapses
`ifdef TIME_12H_EN
      set_time(8'h11, 8'h59, 8'h59, 1'b1);
`else
      set_time(8'h23, 8'h59, 8'h59, 1'b0);
`endif
      tick_n(10);                   // full-day rollover
      set_time(8'h24, 8'h00, 8'h00, 1'b0);
      set_time(8'h10, 8'h00, 8'h5A, 1'b0);
      set_time(8'h00, 8'h60, 8'h00, 1'b0);
      set_time(8'h1A, 8'h00, 8'h00, 1'b0);
`ifdef TIME_12H_EN
      set_time(8'h00, 8'h00, 8'h00, 1'b0);
      set_time(8'h13, 8'h00, 8'h00, 1'b0);
`endif
      tick_n(9);
      drive_set(8'h12, 8'h00, 8'h00, 1'b0);
      pulse = 1'b1; set_valid = 1'b1; cycle();   // set beats the 10th tick
      set_valid = 1'b0; pulse = 1'b0; cycle();
      set_valid = 1'b1;
      tick_n(2);                    // held request reloads every cycle
      set_valid = 1'b0;
      tick_n(12);
      run = 1'b0;
      tick_n(25);
      pulse = 1'b1; cycle();
      run = 1'b1;
      repeat (3) cycle();
      pulse = 1'b0; cycle();
      tick_n(10);
`ifdef TIME_12H_EN
      set_time(8'h11, 8'h59, 8'h59, 1'b0);
      tick_n(10);
      set_time(8'h12, 8'h59, 8'h59, 1'b1);
      tick_n(10);
`endif
      tick_n(4);
      do_reset();                   // mid-count
      drive_set(8'h05, 8'h06, 8'h07, 1'b0);
      set_valid = 1'b1;
      do_reset();                   // mid-set
      set_valid = 1'b0;
      cycle();
`ifdef TIME_12H_EN
      set_time(8'h11, 8'h58, 8'h50, 1'b1);
`else
      set_time(8'h23, 8'h58, 8'h50, 1'b0);
`endif
      for (int i = 0; i < 3000; i++) begin
         pulse = 1'($urandom_range(0, 1));
         run = ($urandom_range(0, 7) != 0);
         set_valid = ($urandom_range(0, 39) == 0);
         if (set_valid) begin
            if ($urandom_range(0, 1) == 0) begin
`ifdef TIME_12H_EN
               drive_set(to_bcd($urandom_range(1, 12)), to_bcd($urandom_range(55, 59)),
                         to_bcd($urandom_range(50, 59)), 1'($urandom_range(0, 1)));
`else
               drive_set(to_bcd($urandom_range(0, 23)), to_bcd($urandom_range(55, 59)),
                         to_bcd($urandom_range(50, 59)), 1'b0);
`endif
            end else begin
               drive_set(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            end
         end
         if ($urandom_range(0, 599) == 0) do_reset();
         else cycle();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/tick_time_counter.md
TICK_TIME_COUNTER -- requirements
Module: tick_time_counter

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 10: number of rising edges on i_pulse per second; legal range 1..255.
REQ-002 SHALL have port i_clk, input, 1: single system clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rstn, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port i_pulse, input, 1: square-wave timebase from the upstream kHz/pulse generator; each rising edge is one tick.
REQ-005 SHALL have port i_run, input, 1: 1 = counting enabled, 0 = ticks ignored.
REQ-006 SHALL have port i_set_valid, input, 1: request to load i_set_hh/mm/ss.
REQ-007 SHALL have ports i_set_hh, i_set_mm, i_set_ss, input, 8 each: packed BCD load values (tens in [7:4], units in [3:0]).
REQ-008 SHALL have ports o_hh, o_mm, o_ss, output reg, 8 each: current time, packed BCD.
REQ-009 SHALL have port o_sec_tick, output reg, 1: one-cycle strobe on each seconds increment.
REQ-010 SHALL have ports o_set_ack and o_set_err, output reg, 1 each: one-cycle load result strobes.

Function
REQ-011 SHALL register i_pulse into r_pulse_d each cycle; tick = i_pulse & ~r_pulse_d.
REQ-012 SHALL maintain sub-second counter r_sub, 0..TICKS_PER_SEC-1, width 8 bits; a tick with i_run=1 increments it, and at TICKS_PER_SEC-1 it wraps to 0 and increments seconds.
REQ-013 SHALL update o_ss/o_mm/o_hh and assert o_sec_tick on the same clock edge at which the wrapping tick is sampled (latency 1 edge from i_pulse rising).
REQ-014 SHALL carry BCD: units 9->0 increments tens; ss 59->00 increments mm; mm 59->00 increments hh; hh 23->00 (24 h mode); full rollover 23:59:59 -> 00:00:00 in one edge.
REQ-015 SHALL ignore ticks while i_run=0 (r_sub and time frozen), while still tracking r_pulse_d so no stale tick fires when i_run returns to 1.
REQ-016 SHALL treat a set request as legal when every BCD digit is 0..9 and hh<=23, mm<=59, ss<=59.
REQ-017 SHALL, on a legal set request, load the three fields, clear r_sub to 0, and pulse o_set_ack for one cycle.
REQ-018 SHALL, on an illegal set request, leave all state unchanged and pulse o_set_err for one cycle.
REQ-019 SHALL give a set request priority over a coincident tick; that tick is discarded and o_sec_tick stays 0.
REQ-020 SHALL evaluate the set request once per cycle while i_set_valid=1; holding it high reloads and re-acks every cycle, and r_sub stays 0.
REQ-021 SHALL keep o_set_ack, o_set_err and o_sec_tick mutually exclusive in any cycle.

Reset
REQ-022 SHALL, while i_rstn=0, force o_hh=o_mm=o_ss=8'h00, r_sub=0, o_sec_tick=o_set_ack=o_set_err=0, and r_pulse_d=1.
REQ-023 SHALL not produce a tick on the first cycle after release, because the upstream generator also resets its pulse to 1.
REQ-024 SHALL, on reset asserted mid-count or mid-set, abandon the operation immediately with no ack or err strobe.

Configuration
REQ-025 SHALL add output o_pm (1 bit, reset 0) and hours range 12,01..11 when TIME_12H_EN is defined.
REQ-026 SHALL, with TIME_12H_EN defined, reset hours to 8'h12 (12:00:00 AM).
REQ-027 SHALL, with TIME_12H_EN defined, roll 11:59:59 -> 12:00:00 toggling o_pm, and 12:59:59 -> 01:00:00 without toggling.
REQ-028 SHALL, with TIME_12H_EN defined, add input i_set_pm, make hh legal only for 01..12, and load o_pm from i_set_pm.
REQ-029 SHALL, without TIME_12H_EN, have no o_pm or i_set_pm ports and follow REQ-014 24 h behaviour.

Verification
REQ-030 Reset, then 10 i_pulse rising edges with i_run=1 -> o_ss=8'h01, exactly one o_sec_tick, r_sub=0.
REQ-031 Set 23:59:59, then 10 ticks -> 00:00:00 on the 10th tick's edge, o_sec_tick=1 on that edge.
REQ-032 Set hh=8'h24 or ss=8'h5A -> o_set_err=1 for one cycle, time unchanged, o_set_ack=0.
REQ-033 i_set_valid asserted on the same edge as the 10th tick with 12:00:00 -> time=12:00:00, o_set_ack=1, o_sec_tick=0, r_sub=0.
REQ-034 i_run=0 while 25 ticks arrive, then i_run=1 with i_pulse held high -> time unchanged, no tick until the next rising edge.
REQ-035 TIME_12H_EN build: set 11:59:59 with i_set_pm=0, then 10 ticks -> 12:00:00, o_pm=1; set 12:59:59, then 10 ticks -> 01:00:00, o_pm unchanged.
